// File: rtl/mario_input_ctrl.sv
// Per-frame player input controller: turns keycodes and collision flags into
// registered per-direction speeds and a GROUND/RISE/FALL jump state.
module mario_input_ctrl #(
   parameter int WALK_SPEED = 2,
   parameter int TERMINAL   = 3,
   parameter int JUMP_V0    = 9,
   parameter int DECAY      = 6,
   parameter int JUMP_CUT   = 3
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   input  logic       on_ground,
   input  logic       hit_ceiling,
   output logic [5:0] right_v,
   output logic [5:0] left_v,
   output logic [5:0] up_v,
   output logic [5:0] down_v,
   output logic [1:0] jump_state,
   output logic       facing_left
);

   typedef enum logic [1:0] {
      GROUND = 2'b00,
      RISE   = 2'b01,
      FALL   = 2'b10
   } jump_state_t;

   localparam logic [7:0] KEY_LEFT  = 8'h04;
   localparam logic [7:0] KEY_RIGHT = 8'h07;
   localparam logic [7:0] KEY_JUMP  = 8'h1A;

   localparam logic [5:0] P_WALK     = 6'(WALK_SPEED);
   localparam logic [5:0] P_TERMINAL = 6'(TERMINAL);
   localparam logic [5:0] P_JUMP_V0  = 6'(JUMP_V0);
   localparam logic [5:0] P_JUMP_CUT = 6'(JUMP_CUT);
   localparam logic [2:0] DECAY_LAST = 3'(DECAY - 1);

   function automatic logic [5:0] sat_inc(input logic [5:0] v, input logic [5:0] lim);
      return (v >= lim) ? lim : v + 6'd1;
   endfunction

   function automatic logic [5:0] sat_dec(input logic [5:0] v);
      return (v == 6'd0) ? 6'd0 : v - 6'd1;
   endfunction

   jump_state_t state_q, state_nxt;
   logic [5:0]  up_speed, up_nxt, down_nxt, left_nxt, right_nxt;
   logic [2:0]  decay_cnt, dc_nxt;
   logic        jump_prev, facing_nxt;
   logic        jump_held, jump_edge, dc_wrap;

   assign jump_held  = (keycode == KEY_JUMP);
   assign jump_edge  = jump_held & ~jump_prev;
   assign dc_wrap    = (decay_cnt == DECAY_LAST);
   assign up_v       = up_speed;
   assign jump_state = state_q;

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= GROUND;
         up_speed    <= 6'd0;
         down_v      <= 6'd0;
         decay_cnt   <= 3'd0;
         left_v      <= 6'd0;
         right_v     <= 6'd0;
         facing_left <= 1'b0;
         jump_prev   <= 1'b1;
      end else begin
         state_q     <= state_nxt;
         up_speed    <= up_nxt;
         down_v      <= down_nxt;
         decay_cnt   <= dc_nxt;
         left_v      <= left_nxt;
         right_v     <= right_nxt;
         facing_left <= facing_nxt;
         jump_prev   <= jump_held;
      end
   end

   always_comb begin
      state_nxt  = state_q;
      up_nxt     = up_speed;
      down_nxt   = down_v;
      dc_nxt     = decay_cnt;
      left_nxt   = (keycode == KEY_LEFT)  ? P_WALK : 6'd0;
      right_nxt  = (keycode == KEY_RIGHT) ? P_WALK : 6'd0;
      facing_nxt = facing_left;
      if (keycode == KEY_LEFT)
         facing_nxt = 1'b1;
      else if (keycode == KEY_RIGHT)
         facing_nxt = 1'b0;

      unique case (state_q)
         GROUND: begin
            up_nxt   = 6'd0;
            down_nxt = 6'd0;
            dc_nxt   = 3'd0;
            // Losing the floor beats a jump press in the same frame.
            if (!on_ground) begin
               state_nxt = FALL;
               down_nxt  = 6'd1;
            end else if (jump_edge) begin
               state_nxt = RISE;
               up_nxt    = P_JUMP_V0;
            end
         end
         RISE: begin
            down_nxt = 6'd0;
            if (hit_ceiling) begin
               state_nxt = FALL;
               up_nxt    = 6'd0;
               down_nxt  = 6'd1;
               dc_nxt    = 3'd0;
            end else begin
               dc_nxt = dc_wrap ? 3'd0 : decay_cnt + 3'd1;
               // Releasing the key early clamps the remaining rise instead of decaying.
               if (!jump_held && (up_speed > P_JUMP_CUT))
                  up_nxt = P_JUMP_CUT;
               else if (dc_wrap)
                  up_nxt = sat_dec(up_speed);
               if (up_nxt == 6'd0) begin
                  state_nxt = FALL;
                  down_nxt  = 6'd1;
                  dc_nxt    = 3'd0;
               end
            end
         end
         FALL: begin
            up_nxt = 6'd0;
            if (on_ground) begin
               state_nxt = GROUND;
               down_nxt  = 6'd0;
               dc_nxt    = 3'd0;
            end else if (dc_wrap) begin
               dc_nxt   = 3'd0;
               down_nxt = sat_inc(down_v, P_TERMINAL);
            end else begin
               dc_nxt = decay_cnt + 3'd1;
            end
         end
         default: begin
            state_nxt = GROUND;
            up_nxt    = 6'd0;
            down_nxt  = 6'd0;
            dc_nxt    = 3'd0;
         end
      endcase
   end

endmodule
